ptvm_change_dispenser: RTL and testbench



---
 rtl/ptvm_pkg.sv | 10 +
 rtl/ptvm_pulse_timer.sv | 16 +
 rtl/ptvm_change_dispenser.sv | 104 ++++++++++
 tb/tb_ptvm_change_dispenser.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ptvm_pkg.sv
// ptvm_pkg: shared coin codes, change limits and dispenser state encoding
package ptvm_pkg;
  localparam logic [2:0] NICKEL      = 3'b001;
  localparam logic [2:0] DIME        = 3'b010;
  localparam logic [2:0] NICKEL_DIME = 3'b011;
  localparam logic [2:0] DIME_DIME   = 3'b100;
  localparam logic [2:0] QUARTER     = 3'b101;
  localparam logic [2:0] MAX_CHANGE  = 3'd4;
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} disp_state_t;
endpackage

// File: rtl/ptvm_pulse_timer.sv
// ptvm_pulse_timer: loadable down-counter timing solenoid pulses and gaps
module ptvm_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clock)
    if (reset) cnt <= '0;
    else cnt <= load ? load_value : (cnt != '0 ? cnt - 1'b1 : cnt);
  assign expired = cnt == '0;
endmodule

// File: rtl/ptvm_change_dispenser.sv
// ptvm_change_dispenser: pays change one coin at a time from nickel/dime tubes
module ptvm_change_dispenser
  import ptvm_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 4,
  parameter int TUBE_MAX     = 15,
  parameter int INIT_NICKELS = 8,
  parameter int INIT_DIMES   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             chg_valid,
  input  logic [2:0]       chg_code,
  output logic             chg_ready,
  input  logic             load_nickel,
  input  logic             load_dime,
  output logic             nickel_sol,
  output logic             dime_sol,
  output logic             busy,
  output logic             done,
  output logic             short_fault,
  output logic [2:0]       remaining,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic             exact_change_only
);
  localparam int TW = $clog2((PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES) + 1);
  localparam int SW = CNT_W + 2;
  disp_state_t state, state_n;
  logic [2:0] rem, rem_n, coin, coin_n;
  logic n_dec, d_dec, t_load, expired;
  logic [TW-1:0] t_val;
  logic [SW-1:0] value;
  ptvm_pulse_timer #(.W(TW)) u_timer (
    .clock(clock), .reset(reset), .load(t_load), .load_value(t_val), .expired(expired)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state      <= IDLE;
      rem        <= '0;
      coin       <= '0;
      nickel_cnt <= CNT_W'(INIT_NICKELS);
      dime_cnt   <= CNT_W'(INIT_DIMES);
    end else begin
      state      <= state_n;
      rem        <= rem_n;
      coin       <= coin_n;
      nickel_cnt <= (load_nickel && !n_dec && nickel_cnt != CNT_W'(TUBE_MAX)) ? nickel_cnt + 1'b1 :
                    (n_dec && !load_nickel) ? nickel_cnt - 1'b1 : nickel_cnt;
      dime_cnt   <= (load_dime && !d_dec && dime_cnt != CNT_W'(TUBE_MAX)) ? dime_cnt + 1'b1 :
                    (d_dec && !load_dime) ? dime_cnt - 1'b1 : dime_cnt;
    end
  always_comb begin
    state_n = state;
    rem_n   = rem;
    coin_n  = coin;
    n_dec   = 1'b0;
    d_dec   = 1'b0;
    t_load  = 1'b0;
    t_val   = '0;
    case (state)
      IDLE: if (chg_valid) begin
        rem_n   = chg_code;
        state_n = chg_code > MAX_CHANGE ? DONE : SELECT;
      end
      SELECT: if (rem == 3'd0) state_n = DONE;
      else if (rem >= 3'd2 && dime_cnt != '0) begin
        coin_n  = DIME;
        rem_n   = rem - 3'd2;
        d_dec   = 1'b1;
        t_load  = 1'b1;
        t_val   = TW'(PULSE_CYCLES - 1);
        state_n = PULSE;
      end else if (nickel_cnt != '0) begin
        coin_n  = NICKEL;
        rem_n   = rem - 3'd1;
        n_dec   = 1'b1;
        t_load  = 1'b1;
        t_val   = TW'(PULSE_CYCLES - 1);
        state_n = PULSE;
      end else state_n = DONE;
      PULSE: if (expired) begin
        t_load  = 1'b1;
        t_val   = TW'(GAP_CYCLES - 1);
        state_n = GAP;
      end
      GAP: if (expired) state_n = SELECT;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // A nonzero residue at DONE always means short pay or an illegal code
  assign chg_ready   = state == IDLE;
  assign busy        = !chg_ready;
  assign done        = state == DONE;
  assign short_fault = done && rem != 3'd0;
  assign remaining   = done ? rem : 3'd0;
  assign nickel_sol  = state == PULSE && coin == NICKEL;
  assign dime_sol    = state == PULSE && coin == DIME;
  assign value       = SW'(nickel_cnt) + (SW'(dime_cnt) << 1);
  assign exact_change_only = nickel_cnt == '0 || value < SW'(MAX_CHANGE);
endmodule

// File: tb/tb_ptvm_change_dispenser.sv
// tb_ptvm_change_dispenser: directed checks of change dispensing, inventory and reset abort
module tb_ptvm_change_dispenser;
  logic clock = 1'b0, reset = 1'b1;
  logic chg_valid = 1'b0, load_nickel = 1'b0, load_dime = 1'b0;
  logic [2:0] chg_code = 3'd0;
  logic chg_ready, nickel_sol, dime_sol, busy, done, short_fault, exact_change_only;
  logic [2:0] remaining;
  logic [3:0] nickel_cnt, dime_cnt;
  int n_checks = 0, n_fail = 0;
  int done_at, ncyc, dcyc, both, first_sol, sh, rm;

  ptvm_change_dispenser dut (
    .clock(clock), .reset(reset), .chg_valid(chg_valid), .chg_code(chg_code),
    .chg_ready(chg_ready), .load_nickel(load_nickel), .load_dime(load_dime),
    .nickel_sol(nickel_sol), .dime_sol(dime_sol), .busy(busy), .done(done),
    .short_fault(short_fault), .remaining(remaining), .nickel_cnt(nickel_cnt),
    .dime_cnt(dime_cnt), .exact_change_only(exact_change_only)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
  endtask

  // accept cycle is 0; the negedge after it observes cycle 1
  task automatic run(input logic [2:0] code, input int ld_at);
    int w = 0;
    while (!chg_ready && w < 40) begin @(negedge clock); w++; end
    chg_valid = 1'b1; chg_code = code;
    done_at = -1; ncyc = 0; dcyc = 0; both = 0; first_sol = -1; sh = 0; rm = 0;
    @(negedge clock) chg_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      load_dime = (k == ld_at);
      if (nickel_sol) ncyc++;
      if (dime_sol) dcyc++;
      if (nickel_sol && dime_sol) both++;
      if ((nickel_sol || dime_sol) && first_sol < 0) first_sol = k;
      if (done) begin done_at = k; sh = short_fault; rm = remaining; break; end
      @(negedge clock);
    end
    load_dime = 1'b0;
    if (done_at < 0) check("done_timeout", done_at, 0);
  endtask

  initial begin
    do_reset();
    check("rst_ready", chg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nickels", nickel_cnt, 8);
    check("rst_dimes", dime_cnt, 8);
    check("rst_eco", exact_change_only, 0);
    // 20c: two dime pulses
    run(3'd4, 0);
    check("c4_first_sol", first_sol, 2);
    check("c4_dime_cyc", dcyc, 8);
    check("c4_nickel_cyc", ncyc, 0);
    check("c4_done_at", done_at, 16);
    check("c4_short", sh, 0);
    check("c4_dimes", dime_cnt, 6);
    check("c4_nickels", nickel_cnt, 8);
    @(negedge clock);
    check("c4_ready_after", chg_ready, 1);
    // 15c: dime then nickel
    do_reset();
    run(3'd3, 0);
    check("c3_dime_cyc", dcyc, 4);
    check("c3_nickel_cyc", ncyc, 4);
    check("c3_both", both, 0);
    check("c3_short", sh, 0);
    check("c3_dimes", dime_cnt, 7);
    check("c3_nickels", nickel_cnt, 7);
    // drain to 0 dimes / 1 nickel, then ask for 10c
    do_reset();
    for (int i = 0; i < 4; i++) run(3'd4, 0);
    for (int i = 0; i < 3; i++) run(3'd2, 0);
    run(3'd1, 0);
    check("drain_dimes", dime_cnt, 0);
    check("drain_nickels", nickel_cnt, 1);
    run(3'd2, 0);
    check("short_nickel_cyc", ncyc, 4);
    check("short_done_at", done_at, 9);
    check("short_flag", sh, 1);
    check("short_rem", rm, 1);
    check("short_nickels", nickel_cnt, 0);
    check("short_eco", exact_change_only, 1);
    // zero and illegal codes
    do_reset();
    run(3'd0, 0);
    check("c0_done_at", done_at, 2);
    check("c0_sol", ncyc + dcyc, 0);
    check("c0_short", sh, 0);
    run(3'd6, 0);
    check("c6_short", sh, 1);
    check("c6_rem", rm, 6);
    check("c6_sol", ncyc + dcyc, 0);
    check("c6_nickels", nickel_cnt, 8);
    check("c6_dimes", dime_cnt, 8);
    @(negedge clock);
    check("c6_short_cleared", short_fault, 0);
    // refill coinciding with dime pick, then saturation
    do_reset();
    run(3'd2, 1);
    check("refill_sel_dcyc", dcyc, 4);
    check("refill_sel_dimes", dime_cnt, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock) load_nickel = 1'b1;
      @(negedge clock) load_nickel = 1'b0;
    end
    check("sat_nickels", nickel_cnt, 15);
    // reset during first pulse of a 20c request
    do_reset();
    chg_valid = 1'b1; chg_code = 3'd4;
    @(negedge clock) chg_valid = 1'b0;
    @(negedge clock);
    check("abort_pulse_on", dime_sol, 1);
    check("abort_pulse_dimes", dime_cnt, 7);
    reset = 1'b1;
    @(negedge clock);
    check("abort_sol", dime_sol | nickel_sol, 0);
    check("abort_done", done, 0);
    check("abort_ready", chg_ready, 1);
    check("abort_dimes", dime_cnt, 8);
    check("abort_nickels", nickel_cnt, 8);
    reset = 1'b0;
    run(3'd1, 0);
    check("post_abort_done_at", done_at, 9);
    check("post_abort_ncyc", ncyc, 4);
    check("post_abort_short", sh, 0);
    check("post_abort_nickels", nickel_cnt, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
